// File: rtl/peri_pkg.sv
// Shared types and constants for the peri_bank peripheral slave.
// FSM state encoding, default read-data patterns and TX status bit layout.
package peri_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] UNMAP_RDAT_DEF = 32'h12345678;
    localparam logic [31:0] IDLE_RDAT_DEF  = 32'h7fffffff;

    localparam int TX_EMPTY_BIT = 0;
    localparam int TX_FULL_BIT  = 1;
    localparam int TX_CNT_LSB   = 2;
    localparam int TX_CNT_W     = 6;

    function automatic logic [31:0] tx_status(input logic [TX_CNT_W-1:0] cnt,
                                              input logic full,
                                              input logic empty);
        logic [31:0] s;
        s = '0;
        s[TX_CNT_LSB +: TX_CNT_W] = cnt;
        s[TX_FULL_BIT]            = full;
        s[TX_EMPTY_BIT]           = empty;
        return s;
    endfunction

endpackage

// File: rtl/peri_bank_if.sv
// Bus and TX stream signals between the core-side master and peri_bank.
// Latency/backpressure are defined by peri_bank; this is wiring only.
interface peri_bank_if;
    logic        regw;
    logic        regr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdat;
    logic        err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport slave (
        input  regw, regr, adr, wdata, tx_ready,
        output ack, rdat, err, tx_valid, tx_data
    );

    modport master (
        output regw, regr, adr, wdata, tx_ready,
        input  ack, rdat, err, tx_valid, tx_data
    );
endinterface

// File: rtl/peri_fifo.sv
// Synchronous FIFO with occupancy count and a head that holds its last value when empty.
// Latency: push visible at head one cycle later. Backpressure: push ignored when full unless popping.
module peri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstz,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = cnt;
    assign head    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/peri_bank.sv
// Peripheral slave: register bank plus TX UART FIFO window; optional decode error via PERI_ERR_EN.
// Latency: ack LAT+1 cycles after a strobe is seen in IDLE. Backpressure: TX write to a full FIFO waits.
module peri_bank
    import peri_pkg::*;
#(
    parameter int          LAT        = 2,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h00012000,
    parameter logic [31:0] TX_ADDR    = 32'h00013000,
    parameter int          TXF_DEPTH  = 8,
    parameter logic [31:0] UNMAP_RDAT = UNMAP_RDAT_DEF,
    parameter logic [31:0] IDLE_RDAT  = IDLE_RDAT_DEF
) (
    input  logic         clk,
    input  logic         rstz,
    peri_bank_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cap;
    logic [29:0] adr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        any_req;

    logic [29:0]   woff;
    logic [IW-1:0] idx;
    logic          bank_hit;
    logic          tx_hit;
    logic          unmapped;
    logic [31:0]   bank [DEPTH];
    logic [31:0]   rd_val;

    logic                     txf_push;
    logic                     txf_pop;
    logic                     txf_full;
    logic                     txf_empty;
    logic [$clog2(TXF_DEPTH):0] txf_count;

    assign any_req  = bus.regw || bus.regr;
    assign woff     = adr_q - BASE_ADDR[31:2];
    assign idx      = woff[IW-1:0];
    assign bank_hit = (adr_q >= BASE_ADDR[31:2]) && (woff < 30'(DEPTH));
    assign tx_hit   = !bank_hit && (adr_q == TX_ADDR[31:2]);
    assign unmapped = !bank_hit && !tx_hit;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                adr_q   <= bus.adr[31:2];
                wdata_q <= bus.wdata;
                wr_q    <= bus.regw;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: if (any_req) begin
                cap     = 1'b1;
                cnt_d   = 4'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // Abort takes priority so a dropped request never commits.
                if (!any_req)               state_d = IDLE;
                else if (cnt_q != '0)       cnt_d   = cnt_q - 1'b1;
                else if (!(wr_q && tx_hit && txf_full)) state_d = ACK;
            end
            ACK:  state_d = HOLD;
            HOLD: if (!any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (state_q == ACK && wr_q && bank_hit) begin
            bank[idx] <= wdata_q;
        end
    end

    assign txf_push = (state_q == ACK) && wr_q && tx_hit;
    assign txf_pop  = bus.tx_valid && bus.tx_ready;

    peri_fifo #(.WIDTH(8), .DEPTH(TXF_DEPTH)) u_txf (
        .clk      (clk),
        .rstz     (rstz),
        .push     (txf_push),
        .push_dat (wdata_q[7:0]),
        .pop      (txf_pop),
        .full     (txf_full),
        .empty    (txf_empty),
        .count    (txf_count),
        .head     (bus.tx_data)
    );

    assign bus.tx_valid = !txf_empty;

    always_comb begin
        rd_val = UNMAP_RDAT;
        if (bank_hit)    rd_val = bank[idx];
        else if (tx_hit) rd_val = tx_status(TX_CNT_W'(txf_count), txf_full, txf_empty);
    end

    assign bus.ack  = (state_q == ACK);
    assign bus.rdat = (bus.ack && !wr_q) ? rd_val : IDLE_RDAT;

`ifdef PERI_ERR_EN
    assign bus.err = bus.ack && unmapped;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_peri_bank.sv
// Scoreboard bench for peri_bank: stimulus queues expected acks/TX bytes, a monitor pops and compares.
module tb_peri_bank;
    import peri_pkg::*;

    localparam logic [31:0] BASE = 32'h00012000;
    localparam logic [31:0] TXA  = 32'h00013000;
    localparam logic [31:0] IDLE_V  = 32'h7fffffff;
    localparam logic [31:0] UNMAP_V = 32'h12345678;
`ifdef PERI_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdat;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rstz = 1'b0;
    always #5 clk = ~clk;

    peri_bank_if bus();

    peri_bank #(
        .LAT(2), .DEPTH(16), .BASE_ADDR(BASE), .TX_ADDR(TXA), .TXF_DEPTH(8),
        .UNMAP_RDAT(UNMAP_V), .IDLE_RDAT(IDLE_V)
    ) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    exp_t       ack_q[$];
    logic [7:0] tx_q[$];
    exp_t       mon_e;
    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no_event", name);
    endfunction

    always @(negedge clk) begin
        if (bus.ack) begin
            if (ack_q.size() == 0) flag("unexpected_ack");
            else begin
                mon_e = ack_q.pop_front();
                chk("ack_rdat", bus.rdat, mon_e.rdat);
                chk("ack_err", 32'(bus.err), 32'(mon_e.err));
            end
        end else begin
            chk("idle_rdat", bus.rdat, IDLE_V);
            chk("idle_err", 32'(bus.err), 32'd0);
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) flag("unexpected_tx_pop");
            else chk("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
        end
    end

    // Called just after a posedge; returns with strobes low and the FSM back in IDLE.
    task automatic bus_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] er, input bit ee, input int hold, output int lat);
        exp_t x;
        x.rdat = wr ? IDLE_V : er;
        x.err  = ee;
        ack_q.push_back(x);
        bus.regw = wr; bus.regr = !wr; bus.adr = a; bus.wdata = d;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.ack) begin lat = n - 1; break; end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL ack_timeout actual=none required=ack adr=%h", a);
        end
        repeat (hold) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.regw = 1'b0; bus.regr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        int l;
        bus_req(1'b1, a, d, 32'h0, (a == 32'h20000000) && ERR_ON, 0, l);
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] er, input bit ee);
        int l;
        bus_req(1'b0, a, 32'h0, er, ee, 0, l);
    endtask

    task automatic no_ack(input string name, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            chk(name, 32'(bus.ack), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int n;
        bus.regw = 1'b0; bus.regr = 1'b0; bus.adr = '0; bus.wdata = '0; bus.tx_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdat", bus.rdat, IDLE_V);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk); #1 rstz = 1'b1;
        @(posedge clk); #1;

        // 1: held read at bank word 0
        bus_req(1'b0, BASE, 32'h0, 32'h0, 1'b0, 3, lat);
        chk("t1_latency", 32'(lat), 32'd3);

        // 2: write then read back, write held after ack
        bus_req(1'b1, BASE + 4, 32'hA5A5A5A5, 32'h0, 1'b0, 5, lat);
        chk("t2_wr_latency", 32'(lat), 32'd3);
        read(BASE + 4, 32'hA5A5A5A5, 1'b0);
        read(BASE, 32'h0, 1'b0);

        // 3: TX window
        write(TXA, 32'h48); tx_q.push_back(8'h48);
        write(TXA, 32'h69); tx_q.push_back(8'h69);
        chk("t3_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("t3_tx_data", 32'(bus.tx_data), 32'h48);
        read(TXA, 32'h00000008, 1'b0);
        bus.tx_ready = 1'b1;
        for (n = 0; n < 20; n++) begin @(negedge clk); if (!bus.tx_valid) break; end
        @(posedge clk); #1 bus.tx_ready = 1'b0;
        chk("t3_tx_drained", 32'(bus.tx_valid), 32'd0);
        chk("t3_tx_hold", 32'(bus.tx_data), 32'h69);
        read(TXA, 32'h00000001, 1'b0);

        // 4: fill FIFO, ninth write stalls until a pop frees space
        for (int i = 0; i < 8; i++) begin
            write(TXA, 32'h30 + i);
            tx_q.push_back(8'(8'h30 + i));
        end
        read(TXA, 32'h00000022, 1'b0);
        begin
            exp_t x;
            x.rdat = IDLE_V; x.err = 1'b0;
            ack_q.push_back(x);
        end
        tx_q.push_back(8'h38);
        bus.regw = 1'b1; bus.adr = TXA; bus.wdata = 32'h38;
        no_ack("t4_stall_noack", 10);
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        @(posedge clk); #1 bus.tx_ready = 1'b0;
        lat = -1;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (bus.ack) begin lat = n; break; end
        end
        chk("t4_ack_after_space", 32'(lat), 32'd2);
        @(posedge clk); #1 bus.regw = 1'b0;
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        for (n = 0; n < 40; n++) begin @(negedge clk); if (!bus.tx_valid) break; end
        @(posedge clk); #1 bus.tx_ready = 1'b0;
        chk("t4_tx_all_popped", 32'(tx_q.size()), 32'd0);
        chk("t4_tx_hold", 32'(bus.tx_data), 32'h38);

        // 5: unmapped read, then an aborted write
        read(32'h20000000, UNMAP_V, ERR_ON);
        bus.regw = 1'b1; bus.adr = BASE + 8; bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.regw = 1'b0;
        no_ack("t5_abort_noack", 6);
        @(posedge clk); #1;
        read(BASE + 8, 32'h0, 1'b0);

        // 6: reset during WAIT of a bank write
        bus.regw = 1'b1; bus.adr = BASE + 12; bus.wdata = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1 rstz = 1'b0;
        bus.regw = 1'b0;
        no_ack("t6_rst_noack", 3);
        chk("t6_rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk); #1 rstz = 1'b1;
        no_ack("t6_post_noack", 5);
        @(posedge clk); #1;
        read(BASE + 12, 32'h0, 1'b0);
        read(BASE + 4, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_ack_empty", 32'(ack_q.size()), 32'd0);
        chk("sb_tx_empty", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule
